// File: rtl/rop3_stream.sv
// Streaming ROP3 engine: per-bit result = mode[{P,S,D}], framed, 2-stage valid/ready.
// Optional word_cnt statistics port enabled with ROP3_STATS_EN.
module rop3_stream #(
   parameter int N     = 8,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       mode,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     P,
   input  logic [N-1:0]     S,
   input  logic [N-1:0]     D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     result,
`ifdef ROP3_STATS_EN
   output logic             out_last,
   output logic [LEN_W-1:0] word_cnt
`else
   output logic             out_last
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t           state_q, state_d;
   logic [7:0]       mode_q, mode_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] acc_inc;
   logic             done_q, done_d;
   logic             v1_q, v1_d;
   logic             last1_q, last1_d;
   logic [N-1:0]     pat1_q, pat1_d;
   logic [N-1:0]     src1_q, src1_d;
   logic [N-1:0]     dst1_q, dst1_d;
   logic             v2_q, v2_d;
   logic             last2_q, last2_d;
   logic [N-1:0]     res_q, res_d;
   logic [N-1:0]     rop_res;
   logic             s1_adv;
   logic             accept;
`ifdef ROP3_STATS_EN
   logic [LEN_W-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      rop_res = '0;
      for (int i = 0; i < N; i++) begin
         rop_res[i] = mode_q[{pat1_q[i], src1_q[i], dst1_q[i]}];
      end
   end

   always_comb begin
      s1_adv   = !v2_q || out_ready;
      acc_inc  = acc_q + 1'b1;
      in_ready = (state_q == RUN) && (acc_q < len_q) && (!v1_q || s1_adv);
      accept   = in_valid && in_ready;

      state_d = state_q;
      mode_d  = mode_q;
      len_d   = len_q;
      acc_d   = acc_q;
      done_d  = 1'b0;
      v1_d    = v1_q;
      last1_d = last1_q;
      pat1_d  = pat1_q;
      src1_d  = src1_q;
      dst1_d  = dst1_q;
      v2_d    = v2_q;
      last2_d = last2_q;
      res_d   = res_q;
`ifdef ROP3_STATS_EN
      cnt_d   = cnt_q;
      if (v2_q && out_ready) cnt_d = cnt_q + 1'b1;
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               mode_d = mode;
               len_d  = len;
               acc_d  = '0;
`ifdef ROP3_STATS_EN
               cnt_d  = '0;
`endif
               if (len == '0) done_d = 1'b1;
               else           state_d = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               acc_d = acc_inc;
               if (acc_inc == len_q) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (v2_q && out_ready && last2_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Stage 1 drains into stage 2 whenever the output slot frees up
      if (accept) begin
         v1_d    = 1'b1;
         pat1_d  = P;
         src1_d  = S;
         dst1_d  = D;
         last1_d = (acc_inc == len_q);
      end else if (v1_q && s1_adv) begin
         v1_d = 1'b0;
      end

      if (s1_adv) begin
         v2_d    = v1_q;
         last2_d = v1_q && last1_q;
         if (v1_q) res_d = rop_res;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= '0;
         len_q   <= '0;
         acc_q   <= '0;
         done_q  <= 1'b0;
         v1_q    <= 1'b0;
         last1_q <= 1'b0;
         pat1_q  <= '0;
         src1_q  <= '0;
         dst1_q  <= '0;
         v2_q    <= 1'b0;
         last2_q <= 1'b0;
         res_q   <= '0;
`ifdef ROP3_STATS_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         len_q   <= len_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         v1_q    <= v1_d;
         last1_q <= last1_d;
         pat1_q  <= pat1_d;
         src1_q  <= src1_d;
         dst1_q  <= dst1_d;
         v2_q    <= v2_d;
         last2_q <= last2_d;
         res_q   <= res_d;
`ifdef ROP3_STATS_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign out_valid = v2_q;
   assign result    = res_q;
   assign out_last  = last2_q;
`ifdef ROP3_STATS_EN
   assign word_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_rop3_stream.sv
// Bench for rop3_stream: vector table of single-word frames, scoreboard queue,
// plus hand-written backpressure, len=0, start-in-RUN and mid-frame reset sequences.
module tb_rop3_stream;
   localparam int N  = 8;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    mode = '0;
   logic [LW-1:0] len = '0;
   logic          busy, done, in_ready, out_valid, out_last;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [N-1:0]  P = '0, S = '0, D = '0;
   logic [N-1:0]  result;
`ifdef ROP3_STATS_EN
   logic [LW-1:0] word_cnt;
`endif

   rop3_stream #(.N(N), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
      .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
      .P(P), .S(S), .D(D), .out_valid(out_valid), .out_ready(out_ready),
      .result(result),
`ifdef ROP3_STATS_EN
      .out_last(out_last), .word_cnt(word_cnt)
`else
      .out_last(out_last)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] mode;
      logic [7:0] p;
      logic [7:0] s;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic [7:0] e;
      logic       l;
   } exp_t;

   vec_t tbl[10];
   exp_t sb[$];
   exp_t pe;

   int   passed = 0;
   int   total = 0;
   int   cyc = 0;
   int   last_hs_cyc = -10;
   int   n_out = 0;
   logic [7:0] exp_in = '0;
   logic       exp_last = 1'b0;
   logic       stalled = 1'b0;
   logic [7:0] held = '0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard: push on input handshake, pop and compare on output handshake
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled && out_valid) chk("hold", result, held);
         stalled = out_valid && !out_ready;
         held    = result;
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               pe = sb.pop_front();
               chk("result", result, pe.e);
               chk("out_last", out_last, pe.l);
            end
            if (out_last) last_hs_cyc = cyc;
         end
         if (in_valid && in_ready) sb.push_back('{exp_in, exp_last});
      end
   end

   task automatic start_frame(input logic [7:0] m, input int l);
      @(posedge clk); #1;
      start = 1'b1; mode = m; len = LW'(l);
      @(posedge clk); #1;
      start = 1'b0; mode = 8'h5A; len = 16'd7;
      chk("busy_after_start", busy, l != 0);
      chk("in_ready_after_start", in_ready, l != 0);
   endtask

   task automatic feed(input int idx, input logic last);
      bit got = 0;
      in_valid = 1'b1;
      P = tbl[idx].p; S = tbl[idx].s; D = tbl[idx].d;
      exp_in = tbl[idx].exp; exp_last = last;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit got = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      chk("done_seen", got, 1);
      chk("done_latency", cyc, last_hs_cyc + 1);
      chk("sb_empty", sb.size(), 0);
      @(negedge clk);
      chk("done_single_pulse", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      int n0;
      tbl[0] = '{8'hCC, 8'h00, 8'h12, 8'hFF, 8'h12};
      tbl[1] = '{8'hCC, 8'hFF, 8'h34, 8'h00, 8'h34};
      tbl[2] = '{8'hCC, 8'hA5, 8'h56, 8'h5A, 8'h56};
      tbl[3] = '{8'h96, 8'hF0, 8'hCC, 8'hAA, 8'h96};
      tbl[4] = '{8'h00, 8'hF0, 8'hCC, 8'hAA, 8'h00};
      tbl[5] = '{8'hFF, 8'hF0, 8'hCC, 8'hAA, 8'hFF};
      tbl[6] = '{8'h96, 8'h0F, 8'h33, 8'h55, 8'h69};
      tbl[7] = '{8'h80, 8'hF0, 8'hCC, 8'hAA, 8'h80};
      tbl[8] = '{8'hC0, 8'hF0, 8'hCC, 8'hAA, 8'hC0};
      tbl[9] = '{8'h66, 8'hF0, 8'hCC, 8'hAA, 8'h66};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_result", result, 0);
`ifdef ROP3_STATS_EN
      chk("rst_word_cnt", word_cnt, 0);
`endif
      rst = 1'b0;

      // Copy-S frame of three words at full rate
      start_frame(8'hCC, 3);
      feed(0, 1'b0);
      feed(1, 1'b0);
      feed(2, 1'b1);
      wait_done();

      // One single-word frame per table entry
      for (int i = 3; i < 10; i++) begin
         start_frame(tbl[i].mode, 1);
         feed(i, 1'b1);
         wait_done();
      end

      // Backpressure: out_ready low for three cycles mid-frame
      n0 = n_out;
      start_frame(8'hCC, 4);
      fork
         begin
            feed(0, 1'b0);
            feed(1, 1'b0);
            feed(2, 1'b0);
            feed(0, 1'b1);
         end
         begin
            for (int k = 0; k < 50; k++) begin
               @(negedge clk);
               if (out_valid) break;
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               if (s > 0) chk("bp_in_ready_low", in_ready, 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_done();
      chk("bp_word_count", n_out - n0, 4);
`ifdef ROP3_STATS_EN
      chk("bp_word_cnt", word_cnt, 4);
`endif

      // Empty frame
      n0 = n_out;
      start_frame(8'hFF, 0);
      chk("len0_done", done, 1);
      chk("len0_out_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("len0_done_low", done, 0);
      chk("len0_in_ready", in_ready, 0);
      chk("len0_busy", busy, 0);
      chk("len0_no_output", n_out - n0, 0);

      // Second start during RUN is ignored
      start_frame(8'hCC, 2);
      feed(0, 1'b0);
      @(posedge clk); #1;
      start = 1'b1; mode = 8'h00; len = 16'd5;
      @(posedge clk); #1;
      start = 1'b0;
      feed(1, 1'b1);
      wait_done();

      // Asynchronous reset between edges with words in flight
      start_frame(8'hCC, 3);
      out_ready = 1'b0;
      feed(0, 1'b0);
      feed(1, 1'b0);
      chk("pre_rst_out_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_result", result, 0);
      chk("arst_out_last", out_last, 0);
      chk("arst_done", done, 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      start_frame(8'h96, 1);
      feed(3, 1'b1);
      wait_done();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
